dec_scan_seq: RTL

//  Upstream sequencer for the 4-to-16 decoder: generates the 4-bit select code W and enable En.

---
 rtl/dec_scan_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/dec_scan_seq.sv
// dec_scan_seq: select-code sequencer for the 4-to-16 decoder.
// Steps W through 0..LAST, holding each code DWELL clocks.
module dec_scan_seq #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned LAST  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic       hold,
    output logic [3:0] W,
    output logic       En,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);
    localparam logic [3:0] W_LAST   = 4'(LAST);

    state_t     state, state_d;
    logic [3:0] w_q, w_d;
    logic [7:0] dwell_cnt, cnt_d;
    logic       mode_q, mode_d;
    logic       wrap_q, wrap_d;

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w_q       <= '0;
            dwell_cnt <= '0;
            mode_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state     <= state_d;
            w_q       <= w_d;
            dwell_cnt <= cnt_d;
            mode_q    <= mode_d;
            wrap_q    <= wrap_d;
        end
    end

    // Next-state logic: stop beats hold beats stepping.
    always_comb begin
        state_d = state;
        w_d     = w_q;
        cnt_d   = dwell_cnt;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        unique case (state)
            IDLE: begin
                w_d   = '0;
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = SCAN;
                    mode_d  = mode;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    w_d     = '0;
                    cnt_d   = '0;
                end else if (!hold) begin
                    if (dwell_cnt == CNT_LAST) begin
                        cnt_d = '0;
                        if (w_q != W_LAST) begin
                            w_d = w_q + 4'd1;
                        end else if (mode_q) begin
                            w_d    = '0;
                            wrap_d = 1'b1;
                        end else begin
                            w_d     = '0;
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = dwell_cnt + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                w_d     = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                w_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // All outputs come straight from registers.
    always_comb begin
        W    = w_q;
        En   = (state == SCAN);
        busy = (state == SCAN);
        done = (state == DONE);
        wrap = wrap_q;
    end

endmodule
